// File: rtl/biu_mem_responder_if.sv
// BIU <-> memory responder handshake bundle.
// Level-held cs/sel request, registered ready/err/data response.
interface biu_mem_responder_if;
  logic        cs_biu;
  logic [1:0]  sel_biu;
  logic [15:0] addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic [31:0] ir;
  logic        ready_bus;
  logic        err;

  modport master (
    output cs_biu,
    output sel_biu,
    output addr,
    output wr_data,
    input  rd_data,
    input  ir,
    input  ready_bus,
    input  err
  );

  modport slave (
    input  cs_biu,
    input  sel_biu,
    input  addr,
    input  wr_data,
    output rd_data,
    output ir,
    output ready_bus,
    output err
  );
endinterface

// File: rtl/biu_mem_responder.sv
// Memory-side responder for the BIU cs/sel/ready handshake.
// Word read/write and 32-bit fetch after fixed wait states.
module biu_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input logic               clk,
  input logic               reset,
  biu_mem_responder_if.slave bus
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH17 = 17'(DEPTH);
  localparam logic [3:0]  WS      = 4'(WAIT_STATES);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_FETCH = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_FETCH_HI,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic [31:0] ir_q, ir_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  logic [15:0] mem_q [DEPTH];
  logic        we;

  logic [16:0] lo_addr;
  logic [16:0] hi_addr;
  logic        lo_ok;
  logic        hi_ok;
  logic [15:0] lo_word;
  logic [15:0] hi_word;

  // Range check in 17 bits so addr+1 never wraps back into range.
  always_comb begin
    lo_addr = {1'b0, addr_q};
    hi_addr = lo_addr + 17'd1;
    lo_ok   = lo_addr < DEPTH17;
    hi_ok   = hi_addr < DEPTH17;
    lo_word = lo_ok ? mem_q[lo_addr[AW-1:0]] : 16'h0000;
    hi_word = hi_ok ? mem_q[hi_addr[AW-1:0]] : 16'h0000;
  end

  // Next-state and next-output logic for the handshake FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    ir_d      = ir_q;
    ready_d   = ready_q;
    err_d     = err_q;
    we        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cs_biu) begin
          sel_d   = bus.sel_biu;
          addr_d  = bus.addr;
          wdata_d = bus.wr_data;
          cnt_d   = WS;
          state_d = (WS == 4'd0) ? S_ACCESS : S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        state_d = S_DONE;
        ready_d = 1'b1;
        unique case (sel_q)
          OP_READ: begin
            rd_data_d = lo_word;
            err_d     = err_q | ~lo_ok;
          end
          OP_WRITE: begin
            we    = lo_ok;
            err_d = err_q | ~lo_ok;
          end
          OP_FETCH: begin
            ir_d    = {lo_word, ir_q[15:0]};
            err_d   = err_q | ~lo_ok;
            state_d = S_FETCH_HI;
            ready_d = 1'b0;
          end
          OP_NOP: begin
            state_d = S_DONE;
          end
          default: begin
            state_d = S_DONE;
          end
        endcase
      end

      S_FETCH_HI: begin
        ir_d    = {ir_q[31:16], hi_word};
        err_d   = err_q | ~hi_ok;
        state_d = S_DONE;
        ready_d = 1'b1;
      end

      S_DONE: begin
        if (!bus.cs_biu) begin
          state_d = S_IDLE;
          ready_d = 1'b0;
          err_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  // FSM state, latched request and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      sel_q     <= 2'b00;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      rd_data_q <= 16'h0000;
      ir_q      <= 32'h0000_0000;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      ir_q      <= ir_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  // Storage array keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[lo_addr[AW-1:0]] <= wdata_q;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.ir        = ir_q;
  assign bus.ready_bus = ready_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_biu_mem_responder.sv
// Directed bench for biu_mem_responder.
// Three instances: WAIT_STATES 0, 1 and 3.
module tb_biu_mem_responder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  biu_mem_responder_if bus0 ();
  biu_mem_responder_if bus1 ();
  biu_mem_responder_if bus2 ();

  logic        cs  [3];
  logic [1:0]  sel [3];
  logic [15:0] ad  [3];
  logic [15:0] wd  [3];
  logic        rdy [3];
  logic        er  [3];
  logic [15:0] rd  [3];
  logic [31:0] irr [3];

  assign bus0.cs_biu  = cs[0];
  assign bus0.sel_biu = sel[0];
  assign bus0.addr    = ad[0];
  assign bus0.wr_data = wd[0];
  assign bus1.cs_biu  = cs[1];
  assign bus1.sel_biu = sel[1];
  assign bus1.addr    = ad[1];
  assign bus1.wr_data = wd[1];
  assign bus2.cs_biu  = cs[2];
  assign bus2.sel_biu = sel[2];
  assign bus2.addr    = ad[2];
  assign bus2.wr_data = wd[2];

  assign rdy[0] = bus0.ready_bus;
  assign er[0]  = bus0.err;
  assign rd[0]  = bus0.rd_data;
  assign irr[0] = bus0.ir;
  assign rdy[1] = bus1.ready_bus;
  assign er[1]  = bus1.err;
  assign rd[1]  = bus1.rd_data;
  assign irr[1] = bus1.ir;
  assign rdy[2] = bus2.ready_bus;
  assign er[2]  = bus2.err;
  assign rd[2]  = bus2.rd_data;
  assign irr[2] = bus2.ir;

  biu_mem_responder #(.DEPTH(256), .WAIT_STATES(0)) u_w0 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus0)
  );

  biu_mem_responder #(.DEPTH(256), .WAIT_STATES(1)) u_w1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  biu_mem_responder #(.DEPTH(256), .WAIT_STATES(3)) u_w3 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int d, output int n);
    n = 0;
    while (rdy[d] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (rdy[d] !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL timeout dut %0d observed ready %b expected 1", d, rdy[d]);
    end
  endtask

  task automatic req(input int d, input logic [1:0] s,
                     input logic [15:0] a, input logic [15:0] w,
                     input int hold, output int lat, output logic e);
    @(negedge clk);
    cs[d]  = 1'b1;
    sel[d] = s;
    ad[d]  = a;
    wd[d]  = w;
    tick();
    wait_ready(d, lat);
    e = er[d];
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_ready", {31'd0, rdy[d]}, 32'd1);
    end
    @(negedge clk);
    cs[d] = 1'b0;
    tick();
    chk("release_ready", {31'd0, rdy[d]}, 32'd0);
  endtask

  int   lat;
  int   n;
  logic e;

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cs[i]  = 1'b0;
      sel[i] = 2'b00;
      ad[i]  = 16'h0000;
      wd[i]  = 16'h0000;
    end
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", {31'd0, rdy[i]}, 32'd0);
      chk("rst_err", {31'd0, er[i]}, 32'd0);
      chk("rst_rd", {16'd0, rd[i]}, 32'd0);
      chk("rst_ir", irr[i], 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) tick();

    req(1, 2'b10, 16'h0005, 16'hBEEF, 0, lat, e);
    chk("w1_wr_lat", lat, 32'd2);
    chk("w1_wr_err", {31'd0, e}, 32'd0);
    req(1, 2'b01, 16'h0005, 16'h0000, 0, lat, e);
    chk("w1_rd_lat", lat, 32'd2);
    chk("w1_rd_data", {16'd0, rd[1]}, 32'h0000_BEEF);
    chk("w1_rd_err", {31'd0, e}, 32'd0);

    req(0, 2'b10, 16'h0010, 16'h1234, 0, lat, e);
    chk("w0_wr_lat", lat, 32'd1);
    req(0, 2'b10, 16'h0011, 16'hABCD, 0, lat, e);
    req(0, 2'b11, 16'h0010, 16'h0000, 0, lat, e);
    chk("w0_fetch_lat", lat, 32'd2);
    chk("w0_fetch_ir", irr[0], 32'h1234_ABCD);
    chk("w0_fetch_err", {31'd0, e}, 32'd0);

    req(1, 2'b01, 16'h0005, 16'h0000, 5, lat, e);
    chk("hold_rd", {16'd0, rd[1]}, 32'h0000_BEEF);

    @(negedge clk);
    cs[1]  = 1'b1;
    sel[1] = 2'b10;
    ad[1]  = 16'h0006;
    wd[1]  = 16'h7777;
    tick();
    @(negedge clk);
    cs[1] = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rdy[1] === 1'b1) n++;
    end
    chk("early_pulse_cycles", n, 32'd1);
    req(1, 2'b01, 16'h0006, 16'h0000, 0, lat, e);
    chk("early_write_landed", {16'd0, rd[1]}, 32'h0000_7777);

    req(1, 2'b10, 16'h0000, 16'hA5A5, 0, lat, e);
    req(1, 2'b10, 16'h0100, 16'h5A5A, 0, lat, e);
    chk("oor_wr_lat", lat, 32'd2);
    chk("oor_wr_err", {31'd0, e}, 32'd1);
    req(1, 2'b01, 16'h0000, 16'h0000, 0, lat, e);
    chk("oor_mem0_kept", {16'd0, rd[1]}, 32'h0000_A5A5);
    chk("oor_mem0_err", {31'd0, e}, 32'd0);
    req(1, 2'b01, 16'h0200, 16'h0000, 0, lat, e);
    chk("oor_rd_data", {16'd0, rd[1]}, 32'd0);
    chk("oor_rd_err", {31'd0, e}, 32'd1);
    req(1, 2'b10, 16'h00FF, 16'hCAFE, 0, lat, e);
    req(1, 2'b11, 16'h00FF, 16'h0000, 0, lat, e);
    chk("oor_fetch_lat", lat, 32'd3);
    chk("oor_fetch_ir", irr[1], 32'hCAFE_0000);
    chk("oor_fetch_err", {31'd0, e}, 32'd1);

    @(negedge clk);
    cs[1]  = 1'b1;
    sel[1] = 2'b01;
    ad[1]  = 16'h0005;
    tick();
    @(negedge clk);
    sel[1] = 2'b10;
    ad[1]  = 16'h0006;
    wd[1]  = 16'h0000;
    wait_ready(1, lat);
    chk("latched_rd", {16'd0, rd[1]}, 32'h0000_BEEF);
    @(negedge clk);
    cs[1] = 1'b0;
    tick();
    chk("reassert_gap_ready", {31'd0, rdy[1]}, 32'd0);
    @(negedge clk);
    cs[1]  = 1'b1;
    sel[1] = 2'b01;
    ad[1]  = 16'h0006;
    wait_ready(1, lat);
    chk("reassert_lat", lat, 32'd3);
    chk("latched_no_write", {16'd0, rd[1]}, 32'h0000_7777);
    @(negedge clk);
    cs[1] = 1'b0;
    tick();

    req(2, 2'b10, 16'h0020, 16'h1111, 0, lat, e);
    chk("w3_wr_lat", lat, 32'd4);
    req(2, 2'b01, 16'h0020, 16'h0000, 0, lat, e);
    chk("w3_rd_data", {16'd0, rd[2]}, 32'h0000_1111);
    @(negedge clk);
    cs[2]  = 1'b1;
    sel[2] = 2'b10;
    ad[2]  = 16'h0020;
    wd[2]  = 16'h5555;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, rdy[2]}, 32'd0);
    chk("mid_rst_err", {31'd0, er[2]}, 32'd0);
    chk("mid_rst_rd", {16'd0, rd[2]}, 32'd0);
    chk("mid_rst_ir_w1", irr[1], 32'd0);
    chk("mid_rst_rd_w1", {16'd0, rd[1]}, 32'd0);
    @(negedge clk);
    cs[2] = 1'b0;
    reset = 1'b1;
    tick();
    req(2, 2'b01, 16'h0020, 16'h0000, 0, lat, e);
    chk("mid_rst_mem_kept", {16'd0, rd[2]}, 32'h0000_1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/biu_mem_responder.md
# biu_mem_responder

Memory-side responder for the bus interface unit's chip-select / select / ready handshake. It accepts one request at a time from the BIU: word read, word write, or 32-bit instruction fetch. It serves each request from an internal word-addressed memory after a fixed number of wait states, then returns `ready_bus` and holds it until the BIU drops `cs_biu`. It sits below the BIU and supplies the data path that the fetch unit and execute unit reach through it.

## Interface
- `DEPTH`, 256: number of 16-bit words in the internal memory; a power of two, 2..65536.
- `WAIT_STATES`, 1: extra cycles inserted before each memory access; 0..15.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `cs_biu` input 1: request strobe from the BIU, level-held for the whole handshake.
- `sel_biu` input 2: operation; 00 nop, 01 read word, 10 write word, 11 instruction fetch.
- `addr` input 16: word address, driven from the BIU fetch/operand address.
- `wr_data` input 16: write data; used only for sel 10.
- `rd_data` output 16: read data; valid while `ready_bus`=1.
- `ir` output 32: fetched instruction; valid while `ready_bus`=1 after sel 11.
- `ready_bus` output 1: request complete.
- `err` output 1: address out of range; qualified by `ready_bus`.

## Operation
- FSM states: IDLE, WAIT, ACCESS, FETCH_HI, DONE.
- IDLE, `cs_biu`=1 at an edge:
  - `sel_biu`, `addr` and `wr_data` are latched.
  - The wait counter loads `WAIT_STATES`.
  - Next state is WAIT, or ACCESS directly if `WAIT_STATES`=0.
- WAIT: the counter decrements each cycle; the FSM moves to ACCESS on the edge where the counter equals 1.
- ACCESS, by latched operation:
  - Read: `rd_data` <= mem[addr], then DONE.
  - Write: mem[addr] <= wr_data, then DONE.
  - Nop: no memory effect and `rd_data` unchanged, then DONE.
  - Fetch: `ir[31:16]` <= mem[addr], then FETCH_HI.
- FETCH_HI: `ir[15:0]` <= mem[addr+1], then DONE. Word order is high word at the lower address.
- Range check: an address is out of range when it is ≥ DEPTH. The fetch high-word address is addr+1, computed in 17 bits with no wrap.
  - On an out-of-range access: no write takes place, the affected read word or `ir` half is loaded with 0, and the sticky `err` is set for the transaction.
- DONE:
  - `ready_bus`=1.
  - The FSM stays in DONE while `cs_biu`=1 (four-phase handshake).
  - On the first edge with `cs_biu`=0 it returns to IDLE, and `ready_bus` and `err` clear.
- Latched inputs are used throughout the transaction. Changes to `sel_biu`, `addr` or `wr_data` after acceptance are ignored.
- If `cs_biu` drops before completion, the operation is not aborted. It finishes, `ready_bus` pulses for exactly one cycle in DONE, and the FSM returns to IDLE.
- Memory is not reset; its contents are undefined until written.

## Timing
- Reset (`reset`=0, asynchronous):
  - State is IDLE.
  - `ready_bus`=0, `err`=0, `rd_data`=0, `ir`=0, and the wait counter is 0.
  - Memory contents are retained.
  - Reset asserted mid-transaction abandons the transaction; a pending write that has not reached ACCESS never occurs.
- Let the acceptance edge be edge 0 and W=`WAIT_STATES`:
  - Read, write and nop: `ready_bus` rises after edge W+1.
  - Fetch: `ready_bus` rises after edge W+2.
- `rd_data`, `ir` and `err` are registered. They are stable from the cycle `ready_bus` rises until the next acceptance.
- `ready_bus` falls after the first edge that samples `cs_biu`=0 in DONE.
- The earliest re-acceptance is the edge after the return to IDLE. This gives at least one idle cycle between transactions, even if `cs_biu` is re-asserted immediately.
- `cs_biu` is ignored in every state except IDLE.

## Test plan
- Write then read, W=1:
  - Stimulus: cs with sel 10, addr 0x0005, wr_data 0xBEEF; release cs on ready; then cs with sel 01, addr 0x0005.
  - Required: the read's `ready_bus` rises 2 edges after acceptance; `rd_data`=0xBEEF; `err`=0.
- Fetch, W=0:
  - Stimulus: preload mem[0x10]=0x1234 and mem[0x11]=0xABCD via writes; issue sel 11, addr 0x10.
  - Required: `ready_bus` rises after edge 2; `ir`=0x1234ABCD.
- Four-phase hold and early release:
  - Stimulus: hold cs 5 cycles past ready.
  - Required: `ready_bus` stays 1 for those cycles and clears one edge after cs falls.
  - Stimulus: drop cs on the cycle after acceptance.
  - Required: `ready_bus` is a one-cycle pulse; the write still lands.
- Out-of-range:
  - Stimulus: DEPTH=256; write to addr 0x0100.
  - Required: `err`=1 with ready; mem[0x00] is unchanged.
  - Stimulus: fetch at 0x00FF.
  - Required: `ir[31:16]`=mem[0xFF], `ir[15:0]`=0, `err`=1.
- Input changes after acceptance:
  - Stimulus: change `addr` and `sel_biu` on the cycle after acceptance.
  - Required: the original latched operation completes.
  - Stimulus: re-assert cs immediately after release.
  - Required: the second request is accepted only after an IDLE cycle.
- Reset mid-operation:
  - Stimulus: with W=3, assert `reset`=0 during WAIT of a write of 0x5555 to 0x20, where mem[0x20]=0x1111.
  - Required: all outputs go to 0 immediately; mem[0x20] reads back 0x1111 afterward.
